// File: rtl/mpu_mem_responder_pkg.sv
// Shared constants and types for the MPU memory responder.
// Holds the default matrix geometry, the element type and the state encodings.
package mpu_mem_responder_pkg;

  localparam int FP_BITS      = 32;
  localparam int MAX_M        = 4;
  localparam int MAX_N        = 4;
  localparam int MATRIX_SLOTS = 4;

  typedef logic [FP_BITS-1:0] float_sp;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_op_t;

  typedef enum logic [1:0] {
    RESP_IDLE  = 2'd0,
    RESP_LOAD  = 2'd1,
    RESP_STORE = 2'd2
  } resp_state_t;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/mpu_mem_index_counter.sv
// Row-major row/column walker bounded by a runtime rows x cols shape.
// `wrap` flags the last column of a row, `last` the final element of the matrix.
module mpu_mem_index_counter #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [ROW_W-1:0] rows,
  input  logic [COL_W-1:0] cols,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             wrap,
  output logic             last
);

  assign wrap = (col == cols - COL_W'(1));
  assign last = wrap && (row == rows - ROW_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (wrap) begin
        col <= '0;
        row <= last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/mpu_mem_responder.sv
// Memory-side responder for MPU matrix load/store transactions.
// Streams a stored matrix out row-major on load, captures a row-major stream on store.
module mpu_mem_responder #(
  parameter int MAX_M        = mpu_mem_responder_pkg::MAX_M,
  parameter int MAX_N        = mpu_mem_responder_pkg::MAX_N,
  parameter int MATRIX_SLOTS = mpu_mem_responder_pkg::MATRIX_SLOTS,
  parameter int FP_BITS      = mpu_mem_responder_pkg::FP_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid_in,
  output logic                            req_ready_out,
  input  logic                            req_op_in,
  input  logic [$clog2(MATRIX_SLOTS)-1:0] req_addr_in,
  input  logic [$clog2(MAX_M):0]          req_m_in,
  input  logic [$clog2(MAX_N):0]          req_n_in,
  output logic                            ld_valid_out,
  input  logic                            ld_ready_in,
  output logic [FP_BITS-1:0]              ld_data_out,
  output logic                            ld_last_out,
  input  logic                            st_valid_in,
  output logic                            st_ready_out,
  input  logic [FP_BITS-1:0]              st_data_in,
  input  logic                            st_last_in,
  output logic                            busy_out,
  output logic                            error_out
);

  import mpu_mem_responder_pkg::*;

  localparam int ADDR_W = $clog2(MATRIX_SLOTS);
  localparam int M_W    = $clog2(MAX_M) + 1;
  localparam int N_W    = $clog2(MAX_N) + 1;
  localparam int DEPTH  = MAX_M * MAX_N;
  localparam int IDX_W  = clog2_min1(DEPTH);

  localparam logic [M_W-1:0] M_LIMIT = M_W'(MAX_M);
  localparam logic [N_W-1:0] N_LIMIT = N_W'(MAX_N);

  resp_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  logic [M_W-1:0]    m_q;
  logic [N_W-1:0]    n_q;

  logic [M_W-1:0]    row;
  logic [N_W-1:0]    col;
  logic              col_wrap;
  logic              cnt_last;
  logic [IDX_W-1:0]  idx;

  logic              accept;
  logic              dims_legal;
  logic              ld_hs;
  logic              st_hs;

  logic [FP_BITS-1:0] mem [MATRIX_SLOTS][DEPTH];

  assign accept     = (state == RESP_IDLE) && req_valid_in;
  assign dims_legal = (req_m_in != '0) && (req_m_in <= M_LIMIT) &&
                      (req_n_in != '0) && (req_n_in <= N_LIMIT);
  assign ld_hs      = ld_valid_out && ld_ready_in;
  assign st_hs      = st_ready_out && st_valid_in;

  // Slots are laid out with a fixed MAX_N row pitch regardless of the request's n.
  assign idx = IDX_W'(row) * IDX_W'(MAX_N) + IDX_W'(col);

  mpu_mem_index_counter #(
    .ROW_W (M_W),
    .COL_W (N_W)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (ld_hs || st_hs),
    .rows    (m_q),
    .cols    (n_q),
    .row     (row),
    .col     (col),
    .wrap    (col_wrap),
    .last    (cnt_last)
  );

  // NOTE: the matrix storage deliberately has no reset; contents survive rst,
  // and leaving it out keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (st_hs) begin
      mem[addr_q][idx] <= st_data_in;
    end
  end

  assign ld_data_out = ld_valid_out ? mem[addr_q][idx] : '0;
  assign ld_last_out = ld_valid_out && cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RESP_IDLE;
      req_ready_out <= 1'b1;
      ld_valid_out  <= 1'b0;
      st_ready_out  <= 1'b0;
      busy_out      <= 1'b0;
      error_out     <= 1'b0;
      addr_q        <= '0;
      m_q           <= '0;
      n_q           <= '0;
    end else begin
      error_out <= 1'b0;
      unique case (state)
        RESP_IDLE: begin
          if (accept) begin
            addr_q <= req_addr_in;
            m_q    <= req_m_in;
            n_q    <= req_n_in;
            if (!dims_legal) begin
              error_out <= 1'b1;
            end else begin
              req_ready_out <= 1'b0;
              busy_out      <= 1'b1;
              if (mem_op_t'(req_op_in) == MEM_LOAD) begin
                state        <= RESP_LOAD;
                ld_valid_out <= 1'b1;
              end else begin
                state        <= RESP_STORE;
                st_ready_out <= 1'b1;
              end
            end
          end
        end

        RESP_LOAD: begin
          if (ld_hs && cnt_last) begin
            state         <= RESP_IDLE;
            ld_valid_out  <= 1'b0;
            busy_out      <= 1'b0;
            req_ready_out <= 1'b1;
          end
        end

        RESP_STORE: begin
          // A mismatch between the stream's last marker and the shape ends the
          // transaction with an error; whatever was written stays written.
          if (st_hs && (cnt_last || st_last_in)) begin
            state         <= RESP_IDLE;
            st_ready_out  <= 1'b0;
            busy_out      <= 1'b0;
            req_ready_out <= 1'b1;
            error_out     <= (cnt_last != st_last_in);
          end
        end

        default: begin
          state         <= RESP_IDLE;
          ld_valid_out  <= 1'b0;
          st_ready_out  <= 1'b0;
          busy_out      <= 1'b0;
          req_ready_out <= 1'b1;
        end
      endcase
    end
  end

  a_channels_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(ld_valid_out && st_ready_out));
  a_busy_matches_state: assert property (@(posedge clk) disable iff (rst)
    busy_out == (state != RESP_IDLE));
  a_last_implies_wrap: assert property (@(posedge clk) disable iff (rst)
    cnt_last |-> col_wrap);

endmodule
